loop_share_sched: RTL and testbench

- Shares one x/y loop-counter datapath between NREQ requesters, using round-robin arbitration.
- A granted requester supplies an initial y value. The block runs the loop to termination:
  - x steps 0 to X_LIMIT, one per enabled cycle.
  - y increments on each step whose new x exceeds Y_THRESH.
- The final y is returned on a valid/ready response channel tagged with the requester id.
- Sits between loop-benchmark clients and the shared counter datapath, in the arithmetic-case suite.

---
 rtl/loop_share_sched_if.sv | 29 ++
 rtl/loop_share_sched.sv | 158 +++++++++++++++
 tb/tb_loop_share_sched.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/loop_share_sched_if.sv
// Request/response bundle for the shared loop-counter scheduler.
// The client side drives requests, step enable and response ready; the scheduler drives the rest.
interface loop_share_sched_if #(
    parameter int W    = 11,
    parameter int NREQ = 2,
    parameter int IDW  = 1
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] y_init;
    logic [NREQ-1:0]   req_gnt;
    logic              step_en;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_y;
    logic [W-1:0]      x;
    logic [W-1:0]      y;
    logic              busy;

    modport master (
        output req, y_init, step_en, rsp_ready,
        input  req_gnt, rsp_valid, rsp_id, rsp_y, x, y, busy
    );

    modport slave (
        input  req, y_init, step_en, rsp_ready,
        output req_gnt, rsp_valid, rsp_id, rsp_y, x, y, busy
    );
endinterface

// File: rtl/loop_share_sched.sv
// Round-robin shared x/y loop-counter datapath; returns the final y tagged with the owner id.
// Optional macro LOOP_RESULT_CHECK_EN adds a sticky chk_err self-check output.
module loop_share_sched #(
    parameter int W        = 11,
    parameter int NREQ     = 2,
    parameter int IDW      = 1,
    parameter int X_LIMIT  = 200,
    parameter int Y_THRESH = 100
) (
    input  logic clk,
    input  logic rst,
    loop_share_sched_if.slave bus
`ifdef LOOP_RESULT_CHECK_EN
    ,
    output logic chk_err
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [W-1:0] X_LIMIT_W    = W'(X_LIMIT);
    localparam logic [W:0]   Y_THRESH_EXT = (W+1)'(Y_THRESH);

    state_t          state_q, state_d;
    logic [W-1:0]    x_q, x_d, y_q, y_d;
    logic [W-1:0]    rsp_y_q, rsp_y_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [IDW-1:0]  last_q, last_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [W:0]      x_next_ext;
    logic [IDW-1:0]  cand;
    logic            found;
    logic [W-1:0]    y_init_arr [NREQ];

`ifdef LOOP_RESULT_CHECK_EN
    localparam logic [W-1:0] Y_DELTA = W'(X_LIMIT - Y_THRESH);
    logic [W-1:0] y_copy_q, y_copy_d;
    logic         chk_err_q, chk_err_d;
`endif

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            y_init_arr[i] = bus.y_init[i*W +: W];
        end
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        rsp_y_d     = rsp_y_q;
        rsp_id_d    = rsp_id_q;
        owner_d     = owner_q;
        last_d      = last_q;
        rsp_valid_d = rsp_valid_q;
        gnt_d       = '0;
        found       = 1'b0;
        cand        = '0;
        x_next_ext  = {1'b0, x_q} + (W+1)'(1);
`ifdef LOOP_RESULT_CHECK_EN
        y_copy_d  = y_copy_q;
        chk_err_d = chk_err_q || (x_q > X_LIMIT_W);
`endif
        case (state_q)
            IDLE: begin
                // Search starts one past the last winner so every requester gets a turn.
                for (int i = 0; i < NREQ; i++) begin
                    if (!found) begin
                        cand = IDW'((int'(last_q) + 1 + i) % NREQ);
                        if (bus.req[cand]) begin
                            found       = 1'b1;
                            x_d         = '0;
                            y_d         = y_init_arr[cand];
                            owner_d     = cand;
                            last_d      = cand;
                            gnt_d[cand] = 1'b1;
                            state_d     = RUN;
`ifdef LOOP_RESULT_CHECK_EN
                            y_copy_d    = y_init_arr[cand];
`endif
                        end
                    end
                end
            end
            RUN: begin
                if (bus.step_en) begin
                    if (x_q < X_LIMIT_W) begin
                        x_d = x_q + W'(1);
                        if (x_next_ext > Y_THRESH_EXT) begin
                            y_d = y_q + W'(1);
                        end
                    end else begin
                        rsp_y_d     = y_q;
                        rsp_id_d    = owner_q;
                        rsp_valid_d = 1'b1;
                        state_d     = DONE;
`ifdef LOOP_RESULT_CHECK_EN
                        if (y_q != y_copy_q + Y_DELTA) begin
                            chk_err_d = 1'b1;
                        end
`endif
                    end
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            rsp_y_q     <= '0;
            rsp_id_q    <= '0;
            owner_q     <= '0;
            last_q      <= IDW'(NREQ - 1);
            rsp_valid_q <= 1'b0;
            gnt_q       <= '0;
`ifdef LOOP_RESULT_CHECK_EN
            y_copy_q    <= '0;
            chk_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            rsp_y_q     <= rsp_y_d;
            rsp_id_q    <= rsp_id_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
            gnt_q       <= gnt_d;
`ifdef LOOP_RESULT_CHECK_EN
            y_copy_q    <= y_copy_d;
            chk_err_q   <= chk_err_d;
`endif
        end
    end

    assign bus.req_gnt   = gnt_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.busy      = (state_q != IDLE);
`ifdef LOOP_RESULT_CHECK_EN
    assign chk_err       = chk_err_q;
`endif
endmodule

// File: tb/tb_loop_share_sched.sv
// Directed bench for loop_share_sched: single run, round-robin, stall, backpressure, mid-run reset, y wrap.
module tb_loop_share_sched;
    localparam int W    = 11;
    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   err_count   = 0;
    int   check_count = 0;
`ifdef LOOP_RESULT_CHECK_EN
    logic chk_err;
`endif

    loop_share_sched_if #(.W(W), .NREQ(NREQ), .IDW(IDW)) bus_if ();

    loop_share_sched #(.W(W), .NREQ(NREQ), .IDW(IDW), .X_LIMIT(200), .Y_THRESH(100)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_if)
`ifdef LOOP_RESULT_CHECK_EN
        ,
        .chk_err (chk_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] req, input logic [W-1:0] y0,
                                 input logic [W-1:0] y1, input logic step, input logic ready);
        bus_if.req       = req;
        bus_if.y_init    = {y1, y0};
        bus_if.step_en   = step;
        bus_if.rsp_ready = ready;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(2'b00, '0, '0, 1'b1, 1'b0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Counts edges until rsp_valid rises; an expired budget shows up as a wrong count.
    task automatic runUntilValid(input int max_edges, output int edges);
        edges = 0;
        while (!bus_if.rsp_valid && edges < max_edges) begin
            tick();
            edges++;
        end
    endtask

    task automatic waitGrant(input int max_edges, output int edges);
        edges = 0;
        while (bus_if.req_gnt == '0 && edges < max_edges) begin
            tick();
            edges++;
        end
    endtask

    initial begin
        int edges;
        logic stable;
        logic [NREQ-1:0] exp_gnt;
        logic [W-1:0] exp_y;

        // Reset values
        doReset();
        checkOutput("rst_busy", bus_if.busy, 0);
        checkOutput("rst_x", bus_if.x, 0);
        checkOutput("rst_y", bus_if.y, 0);
        checkOutput("rst_valid", bus_if.rsp_valid, 0);
        checkOutput("rst_id", bus_if.rsp_id, 0);
        checkOutput("rst_rsp_y", bus_if.rsp_y, 0);
        checkOutput("rst_gnt", bus_if.req_gnt, 0);

        // Single request from requester 0
        applyStimulus(2'b01, 11'd100, 11'd0, 1'b1, 1'b0);
        tick();
        checkOutput("single_gnt", bus_if.req_gnt, 2'b01);
        checkOutput("single_load_x", bus_if.x, 0);
        checkOutput("single_load_y", bus_if.y, 100);
        checkOutput("single_busy", bus_if.busy, 1);
        bus_if.req = 2'b00;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (n == 1) checkOutput("single_gnt_pulse", bus_if.req_gnt, 0);
            if (n == 100) checkOutput("single_y_hold", bus_if.y, 100);
            if (n == 101) checkOutput("single_y_inc", bus_if.y, 101);
        end
        checkOutput("single_x_end", bus_if.x, 200);
        checkOutput("single_y_end", bus_if.y, 200);
        checkOutput("single_not_yet", bus_if.rsp_valid, 0);
        tick();
        checkOutput("single_valid", bus_if.rsp_valid, 1);
        checkOutput("single_id", bus_if.rsp_id, 0);
        checkOutput("single_rsp_y", bus_if.rsp_y, 200);
        bus_if.rsp_ready = 1'b1;
        tick();
        checkOutput("single_ack_valid", bus_if.rsp_valid, 0);
        checkOutput("single_ack_busy", bus_if.busy, 0);
        checkOutput("single_hold_x", bus_if.x, 200);

        // Round-robin with both requesters held high
        doReset();
        applyStimulus(2'b11, 11'd10, 11'd500, 1'b1, 1'b1);
        for (int t = 0; t < 4; t++) begin
            exp_gnt = (t % 2 == 0) ? 2'b01 : 2'b10;
            exp_y   = (t % 2 == 0) ? 11'd110 : 11'd600;
            waitGrant(5, edges);
            checkOutput($sformatf("rr_gnt%0d", t), bus_if.req_gnt, exp_gnt);
            runUntilValid(300, edges);
            checkOutput($sformatf("rr_lat%0d", t), edges, 201);
            checkOutput($sformatf("rr_id%0d", t), bus_if.rsp_id, t % 2);
            checkOutput($sformatf("rr_y%0d", t), bus_if.rsp_y, exp_y);
        end

        // Stall: step_en toggles each cycle in RUN
        doReset();
        applyStimulus(2'b01, 11'd100, 11'd0, 1'b1, 1'b0);
        tick();
        bus_if.req = 2'b00;
        edges = 0;
        bus_if.step_en = 1'b1;
        while (!bus_if.rsp_valid && edges < 1000) begin
            tick();
            edges++;
            bus_if.step_en = ~bus_if.step_en;
            if (edges == 10) checkOutput("stall_x10", bus_if.x, 5);
        end
        bus_if.step_en = 1'b1;
        checkOutput("stall_lat", edges, 401);
        checkOutput("stall_rsp_y", bus_if.rsp_y, 200);

        // Backpressure with requester 1 pending
        doReset();
        applyStimulus(2'b01, 11'd7, 11'd33, 1'b1, 1'b0);
        tick();
        checkOutput("bp_gnt0", bus_if.req_gnt, 2'b01);
        bus_if.req = 2'b10;
        runUntilValid(300, edges);
        checkOutput("bp_lat", edges, 201);
        checkOutput("bp_rsp_y", bus_if.rsp_y, 107);
        stable = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_y !== 11'd107 ||
                bus_if.rsp_id !== 1'b0 || bus_if.req_gnt !== 2'b00) stable = 1'b0;
        end
        checkOutput("bp_stable", stable, 1);
        bus_if.rsp_ready = 1'b1;
        tick();
        checkOutput("bp_ack_valid", bus_if.rsp_valid, 0);
        checkOutput("bp_ack_nogrant", bus_if.req_gnt, 0);
        bus_if.rsp_ready = 1'b0;
        tick();
        checkOutput("bp_gnt1", bus_if.req_gnt, 2'b10);
        checkOutput("bp_load_y", bus_if.y, 33);

        // Mid-run reset at x=150
        doReset();
        applyStimulus(2'b01, 11'd100, 11'd0, 1'b1, 1'b0);
        tick();
        bus_if.req = 2'b00;
        for (int n = 0; n < 150; n++) tick();
        checkOutput("mid_x150", bus_if.x, 150);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid_rst_x", bus_if.x, 0);
        checkOutput("mid_rst_y", bus_if.y, 0);
        checkOutput("mid_rst_busy", bus_if.busy, 0);
        checkOutput("mid_rst_gnt", bus_if.req_gnt, 0);
        applyStimulus(2'b01, 11'd5, 11'd0, 1'b1, 1'b0);
        tick();
        checkOutput("mid_regnt", bus_if.req_gnt, 2'b01);
        checkOutput("mid_reload_y", bus_if.y, 5);
        bus_if.req = 2'b00;
        tick();
        checkOutput("mid_restart_x", bus_if.x, 1);

        // y wraps modulo 2^W
        doReset();
        applyStimulus(2'b01, 11'd2000, 11'd0, 1'b1, 1'b0);
        tick();
        bus_if.req = 2'b00;
        runUntilValid(300, edges);
        checkOutput("wrap_lat", edges, 201);
        checkOutput("wrap_rsp_y", bus_if.rsp_y, 52);
`ifdef LOOP_RESULT_CHECK_EN
        checkOutput("wrap_chk_err", chk_err, 0);
`endif

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end
endmodule
